data_splice_arbiter: RTL
========================

# data_splice_arbiter

Two-port packet arbiter placed after two data splice instances in the network input path. Each port delivers 134-bit packet words, which the arbiter stores in a per-port store-and-forward buffer. Only complete packets are committed. Committed packets are forwarded whole onto one 134-bit bus, with round-robin selection at packet boundaries. Packets that do not fit, or that arrive malformed, are dropped without corrupting buffered data.

## Interface
Parameters:
- FIFO_DEPTH, 128: words per port buffer; power of two.
- MAX_PKT_WORDS, 96: largest accepted packet in words (1536 B).

Ports:
- i_clk  in  1  sole clock.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_pkt_wr_p0  in  1  word valid, port 0.
- iv_pkt_p0  in  134  word, port 0. Fields: [133:132] 01 head / 11 middle / 10 tail; [131:128] invalid bytes; [127:0] data, MSB-first.
- i_pkt_wr_p1  in  1  word valid, port 1.
- iv_pkt_p1  in  134  word, port 1; same format as port 0.
- o_pkt_wr  out  1  output word valid.
- ov_pkt  out  134  output word, same format as the inputs.
- o_src_port  out  1  source port of the current output word.
- ov_arb_state  out  2  arbiter FSM state, for debug.
- ov_drop_cnt_p0 / ov_drop_cnt_p1  out  16  dropped-packet counters (present only with the macro).

## Operation
Write side, independent per port. FSM states are recv_idle, recv_s and recv_discard.
- recv_idle, head word arrives:
  - If free >= MAX_PKT_WORDS: write the word and go to recv_s. Free = FIFO_DEPTH − (wr_ptr − rd_ptr).
  - Otherwise: go to recv_discard and count one drop.
- recv_idle, non-head word arrives: ignore it; no count.
- recv_s, middle word: write it.
- recv_s, tail word: write it, set committed ptr = wr_ptr+1, increment committed packet count, go to recv_idle.
- recv_s, head word arrives: roll wr_ptr back to the committed ptr and count one drop. Then apply the recv_idle head rule to the new head in the same cycle.
- recv_s, packet word count would exceed MAX_PKT_WORDS: roll back, count one drop, go to recv_discard.
- recv_discard: ignore words until a tail, then go to recv_idle. A head arriving here is handled as in recv_idle.
- Words are never backpressured.

Read side uses an asynchronous-read buffer and FSM states arb_idle (00), arb_p0 (01) and arb_p1 (10).
- arb_idle: if any port's committed count > 0, grant one port. When both are eligible, grant the port other than last_grant. Update last_grant.
- arb_pX: read one word per cycle and register it to ov_pkt/o_pkt_wr/o_src_port. On reading the tail flag, decrement the count and return to arb_idle.
- Committed count: simultaneous increment and decrement leaves it unchanged. Width is log2(FIFO_DEPTH)+1.
- The read side only reads up to the committed ptr, so it never underflows mid-packet.
- Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.

## Timing
- Reset values:
  - o_pkt_wr 0, ov_pkt 0, o_src_port 0, ov_arb_state 00.
  - Counters 0, pointers 0, last_grant 1 (so port 0 is granted first).
- Tail committed at edge N: grant at N+1; first output word valid at N+2; one word per cycle after that.
- At least one idle cycle (o_pkt_wr = 0) separates consecutive output packets.
- o_pkt_wr is low whenever ov_pkt is not a valid word; ov_pkt is then 0.
- Reset mid-packet: all buffered and partial packets are lost; output goes low immediately (asynchronous).

## Configuration
- DATA_SPLICE_ARB_DROP_CNT_EN defined:
  - ov_drop_cnt_p0/p1 are present.
  - Each counter increments once per dropped or aborted packet and saturates at 0xFFFF.
- Macro undefined: the counter ports and logic are absent; drop behaviour is unchanged.

## Structure
- Shared package holds:
  - flag constants HEAD=2'b01, MID=2'b11, TAIL=2'b10;
  - arbiter state encodings;
  - field bit positions.
- One sub-module, pkt_commit_fifo, instantiated twice:
  - holds the buffer, write FSM, commit/rollback pointers, committed count and drop counter;
  - exposes the committed count, an asynchronous read word and a read strobe.

## Test plan
- Port 0 sends a 4-word packet (head, 2× middle, tail with invalid=5): output is 4 words, source 0, identical words, first word 2 cycles after the tail.
- Both ports commit a 3-word packet in the same cycle after reset: port 0 is forwarded, then after one idle cycle port 1; repeated together, order continues 0,1,0,1.
- Port 1 buffer holds 40 unread words (FIFO_DEPTH=128) and a new head arrives: the packet is dropped, the drop count becomes 1, and a later head admitted with free >= 96 is forwarded intact.
- Port 0 sends head, middle, then another head: the first packet is rolled back (never output), drop count is 1, and the second packet is forwarded correctly.
- Port 0 sends a 97-word packet: discarded, nothing output, drop count 1; the next 2-word packet passes.
- Reset asserted during output of word 2 of 5: o_pkt_wr drops immediately; after release, both buffers are empty and no stale words are output.

Source files
------------

// File: rtl/data_splice_arbiter_pkg.sv
// data_splice_arbiter_pkg: shared word-format constants and state encodings for the splice arbiter.
package data_splice_arbiter_pkg;
    localparam int PKT_W   = 134;
    localparam int FLAG_HI = 133;
    localparam int FLAG_LO = 132;
    localparam logic [1:0] HEAD = 2'b01;
    localparam logic [1:0] MID  = 2'b11;
    localparam logic [1:0] TAIL = 2'b10;
    typedef enum logic [1:0] {ARB_IDLE = 2'b00, ARB_P0 = 2'b01, ARB_P1 = 2'b10} arb_state_t;
    typedef enum logic [1:0] {RECV_IDLE, RECV_S, RECV_DISCARD} recv_state_t;
endpackage

// File: rtl/pkt_commit_fifo.sv
// pkt_commit_fifo: store-and-forward port buffer that commits whole packets and rolls back bad ones.
// Drop counter present only with DATA_SPLICE_ARB_DROP_CNT_EN.
module pkt_commit_fifo
    import data_splice_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH    = 128,
    parameter int MAX_PKT_WORDS = 96
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_wr,
    input  logic [PKT_W-1:0]            iv_word,
    input  logic                        i_rd,
    output logic [PKT_W-1:0]            ov_rd_word,
    output logic [$clog2(FIFO_DEPTH):0] ov_pkt_cnt
`ifdef DATA_SPLICE_ARB_DROP_CNT_EN
    ,
    output logic [15:0]                 ov_drop_cnt
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef logic [AW:0] ptr_t;

    logic [PKT_W-1:0] mem [FIFO_DEPTH];
    recv_state_t state, state_d;
    ptr_t wr_ptr, cmt_ptr, rd_ptr, pkt_len, base_ptr;
    logic [1:0] flag;
    logic head, admit, over, wr_en, rollback, reject, commit, rd_tail;

    assign flag       = iv_word[FLAG_HI:FLAG_LO];
    assign head       = i_wr && flag == HEAD;
    // Free space is judged from the committed pointer so a rolled-back partial packet frees its words at once.
    assign admit      = ptr_t'(FIFO_DEPTH) - (cmt_ptr - rd_ptr) >= ptr_t'(MAX_PKT_WORDS);
    assign over       = pkt_len >= ptr_t'(MAX_PKT_WORDS);
    assign base_ptr   = rollback ? cmt_ptr : wr_ptr;
    assign ov_rd_word = mem[rd_ptr[AW-1:0]];
    assign rd_tail    = i_rd && ov_rd_word[FLAG_HI:FLAG_LO] == TAIL;

    always_comb begin
        state_d  = state;
        wr_en    = 1'b0;
        rollback = 1'b0;
        reject   = 1'b0;
        commit   = 1'b0;
        if (head) begin
            rollback = state == RECV_S;
            reject   = !admit;
            wr_en    = admit;
            state_d  = admit ? RECV_S : RECV_DISCARD;
        end else if (i_wr && state == RECV_S) begin
            if (over || (flag != MID && flag != TAIL)) begin
                rollback = 1'b1;
                state_d  = RECV_DISCARD;
            end else begin
                wr_en   = 1'b1;
                commit  = flag == TAIL;
                state_d = flag == TAIL ? RECV_IDLE : RECV_S;
            end
        end else if (i_wr && state == RECV_DISCARD && flag == TAIL) begin
            state_d = RECV_IDLE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_en) mem[base_ptr[AW-1:0]] <= iv_word;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= RECV_IDLE;
            wr_ptr     <= '0;
            cmt_ptr    <= '0;
            rd_ptr     <= '0;
            pkt_len    <= '0;
            ov_pkt_cnt <= '0;
        end else begin
            state      <= state_d;
            wr_ptr     <= base_ptr + ptr_t'(wr_en);
            if (commit) cmt_ptr <= wr_ptr + ptr_t'(1);
            pkt_len    <= head ? ptr_t'(1) : pkt_len + ptr_t'(wr_en);
            rd_ptr     <= rd_ptr + ptr_t'(i_rd);
            ov_pkt_cnt <= ov_pkt_cnt + ptr_t'(commit) - ptr_t'(rd_tail);
        end
    end

`ifdef DATA_SPLICE_ARB_DROP_CNT_EN
    // An abort and a refused new head can coincide, so one cycle may add two drops.
    logic [17:0] drop_sum;
    assign drop_sum = {2'b00, ov_drop_cnt} + 18'(rollback) + 18'(reject);
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) ov_drop_cnt <= '0;
        else ov_drop_cnt <= drop_sum > 18'hFFFF ? 16'hFFFF : drop_sum[15:0];
    end
`endif
endmodule

// File: rtl/data_splice_arbiter.sv
// data_splice_arbiter: two-port packet buffer with round-robin whole-packet forwarding.
// Define DATA_SPLICE_ARB_DROP_CNT_EN to expose per-port saturating drop counters.
module data_splice_arbiter
    import data_splice_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH    = 128,
    parameter int MAX_PKT_WORDS = 96
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_pkt_wr_p0,
    input  logic [PKT_W-1:0] iv_pkt_p0,
    input  logic             i_pkt_wr_p1,
    input  logic [PKT_W-1:0] iv_pkt_p1,
    output logic             o_pkt_wr,
    output logic [PKT_W-1:0] ov_pkt,
    output logic             o_src_port,
    output logic [1:0]       ov_arb_state
`ifdef DATA_SPLICE_ARB_DROP_CNT_EN
    ,
    output logic [15:0]      ov_drop_cnt_p0,
    output logic [15:0]      ov_drop_cnt_p1
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    arb_state_t state, state_d;
    logic last_grant, last_grant_d, rd0, rd1;
    logic [PKT_W-1:0] word0, word1, word;
    logic [CW-1:0] cnt0, cnt1;

    pkt_commit_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .MAX_PKT_WORDS(MAX_PKT_WORDS)) u_fifo_p0 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_wr(i_pkt_wr_p0), .iv_word(iv_pkt_p0),
        .i_rd(rd0), .ov_rd_word(word0), .ov_pkt_cnt(cnt0)
`ifdef DATA_SPLICE_ARB_DROP_CNT_EN
        , .ov_drop_cnt(ov_drop_cnt_p0)
`endif
    );

    pkt_commit_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .MAX_PKT_WORDS(MAX_PKT_WORDS)) u_fifo_p1 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_wr(i_pkt_wr_p1), .iv_word(iv_pkt_p1),
        .i_rd(rd1), .ov_rd_word(word1), .ov_pkt_cnt(cnt1)
`ifdef DATA_SPLICE_ARB_DROP_CNT_EN
        , .ov_drop_cnt(ov_drop_cnt_p1)
`endif
    );

    assign rd0          = state == ARB_P0;
    assign rd1          = state == ARB_P1;
    assign word         = rd1 ? word1 : word0;
    assign ov_arb_state = state;

    always_comb begin
        state_d      = state;
        last_grant_d = last_grant;
        if (state == ARB_IDLE) begin
            if (cnt0 != '0 && (cnt1 == '0 || last_grant)) begin
                state_d      = ARB_P0;
                last_grant_d = 1'b0;
            end else if (cnt1 != '0) begin
                state_d      = ARB_P1;
                last_grant_d = 1'b1;
            end
        end else if (word[FLAG_HI:FLAG_LO] == TAIL) begin
            state_d = ARB_IDLE;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= ARB_IDLE;
            last_grant <= 1'b1;
            o_pkt_wr   <= 1'b0;
            ov_pkt     <= '0;
            o_src_port <= 1'b0;
        end else begin
            state      <= state_d;
            last_grant <= last_grant_d;
            o_pkt_wr   <= rd0 | rd1;
            ov_pkt     <= (rd0 | rd1) ? word : '0;
            o_src_port <= rd1;
        end
    end
endmodule
